hazard_stall_unit: RTL and testbench
====================================

Name: hazard_stall_unit

Overview:
- Sits in the ID stage, directly upstream of the control unit. Drives its `stall` input and the PC/IF-ID write enables.
- Detects load-use data hazards, memory-wait freezes and taken-branch flushes.
- Sequences the resulting stalls, holds and flushes with a small FSM.
- Keeps saturating performance counters of stall and flush cycles.

Parameters:
- REG_ADDR_W, 5, register index width
- CNT_W, 16, width of each performance counter

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  reset, synchronous, active-high
- id_rs1  input  REG_ADDR_W  rs1 of the instruction in ID
- id_rs2  input  REG_ADDR_W  rs2 of the instruction in ID
- id_uses_rs1  input  1  ID instruction reads rs1
- id_uses_rs2  input  1  ID instruction reads rs2
- ex_memread  input  1  memread of the instruction in EX (ID/EX register)
- ex_rd  input  REG_ADDR_W  destination register of the EX instruction
- ex_branch_taken  input  1  branch in EX resolved taken this cycle
- mem_req  input  1  MEM stage has an outstanding data-memory access
- mem_ready  input  1  data memory completes the access this cycle
- stall  output  1  to control unit; forces ID control signals to NOP
- pc_write  output  1  PC register enable
- if_id_write  output  1  IF/ID register enable
- if_id_flush  output  1  IF/ID register clear (inserts NOP)
- pipe_hold  output  1  freeze ID/EX, EX/MEM and MEM/WB registers
- stall_cnt  output  CNT_W  cycles with `stall` = 1, saturating
- flush_cnt  output  CNT_W  cycles with `if_id_flush` = 1, saturating

Behaviour:
- Clocking and reset:
  - Single clock `clk`. Reset `rst` is synchronous and active-high.
  - While `rst` = 1, outputs are forced to idle values: stall=0, pc_write=1, if_id_write=1, if_id_flush=0, pipe_hold=0.
  - After reset: FSM in RUN, stall_cnt=0, flush_cnt=0.
- Output timing:
  - Control outputs are combinational (Mealy) from FSM state and the current-cycle inputs, so the control unit sees `stall` in the same cycle.
  - Zero-cycle latency from hazard to stall.
- Hazard terms (combinational):
  - load_use = ex_memread & (ex_rd != 0) & ((id_uses_rs1 & ex_rd == id_rs1) | (id_uses_rs2 & ex_rd == id_rs2)).
  - mem_wait = mem_req & ~mem_ready.
- FSM states: RUN, MEM_WAIT, FLUSH_HOLD.
- RUN:
  - Priority 1, mem_wait: go to MEM_WAIT. This cycle: pipe_hold=1, pc_write=0, if_id_write=0, stall=0.
  - Priority 2, ex_branch_taken: if_id_flush=1, stall=1 (squashes the ID instruction), pc_write=1. A load_use in the same cycle is ignored because the ID instruction is wrong-path. Stay in RUN.
  - Priority 3, load_use: stall=1, pc_write=0, if_id_write=0, for exactly one cycle. The next cycle's EX holds the bubble, so load_use clears on its own.
  - Otherwise: idle values.
- MEM_WAIT:
  - Hold: pipe_hold=1, pc_write=0, if_id_write=0, stall=0.
  - If mem_ready=1 this cycle: release. Outputs return to idle values this cycle, and the FSM returns to RUN.
  - If ex_branch_taken was sampled when entering MEM_WAIT: the flush is latched (flag flush_pend) and the FSM goes to FLUSH_HOLD instead of RUN.
- FLUSH_HOLD:
  - One cycle: if_id_flush=1, stall=1, pc_write=1. Then go to RUN.
  - A new mem_wait in this cycle takes precedence: go to MEM_WAIT with flush_pend kept.
- Counters:
  - stall_cnt increments on every cycle with stall=1 and rst=0.
  - flush_cnt increments on every cycle with if_id_flush=1 and rst=0.
  - Both saturate at all-ones with no wrap.
- Reset mid-operation: from any state, reset returns to RUN, clears flush_pend and clears both counters on the next edge.
- ex_rd = 0 never produces a stall.
- The unit never asserts pc_write=0 and if_id_flush=1 in the same cycle.

Decomposition:
- Shared package `pipe_pkg`:
  - FSM state enum (RUN, MEM_WAIT, FLUSH_HOLD).
  - REG_ADDR_W default constant.
  - Idle-value constants for the five control outputs.
- One sub-module `sat_counter` (params W; ports clk, rst, inc, count), instantiated twice.
- Hazard compare and FSM stay in the top module.

Test Plan:
- ex_memread=1, ex_rd=5, id_rs1=5, id_uses_rs1=1 -> that cycle stall=1, pc_write=0, if_id_write=0. Next cycle with ex_memread=0 -> idle values. stall_cnt=1.
- Same as first, but ex_rd=0 -> no stall, stall_cnt stays 0.
- load_use and ex_branch_taken in the same cycle -> if_id_flush=1, stall=1, pc_write=1. flush_cnt=1, stall_cnt=1.
- mem_req=1, mem_ready=0 for 3 cycles, then mem_ready=1 -> pipe_hold=1 for 3 cycles, idle values on cycle 4, FSM in RUN.
- mem_wait entered together with ex_branch_taken; mem_ready after 2 cycles -> a FLUSH_HOLD cycle with if_id_flush=1, then RUN.
- CNT_W=4, hold load_use for 20 cycles -> stall_cnt saturates at 15. Assert rst in MEM_WAIT -> next cycle RUN, counters 0, pipe_hold=0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and constants for the ID-stage hazard/stall logic.
package pipe_pkg;

  localparam int DEF_REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    RUN,
    MEM_WAIT,
    FLUSH_HOLD
  } hsu_state_t;

  // Values the five pipeline controls take when nothing is stalled, held or flushed
  localparam logic IDLE_STALL       = 1'b0;
  localparam logic IDLE_PC_WRITE    = 1'b1;
  localparam logic IDLE_IF_ID_WRITE = 1'b1;
  localparam logic IDLE_IF_ID_FLUSH = 1'b0;
  localparam logic IDLE_PIPE_HOLD   = 1'b0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; one cycle from inc to updated count, sticks at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_stall_unit.sv
// Load-use / memory-wait / branch-flush sequencing for the ID stage.
// Controls are Mealy (same-cycle response); perf counters update on the next edge.
module hazard_stall_unit
  import pipe_pkg::*;
#(
  parameter int REG_ADDR_W = DEF_REG_ADDR_W,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic                  ex_memread,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_branch_taken,
  input  logic                  mem_req,
  input  logic                  mem_ready,
  output logic                  stall,
  output logic                  pc_write,
  output logic                  if_id_write,
  output logic                  if_id_flush,
  output logic                  pipe_hold,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  hsu_state_t state, state_nxt;
  logic       flush_pend, flush_pend_nxt;
  logic       load_use;
  logic       mem_wait;

  assign load_use = ex_memread && (ex_rd != '0) &&
                    ((id_uses_rs1 && (ex_rd == id_rs1)) ||
                     (id_uses_rs2 && (ex_rd == id_rs2)));
  assign mem_wait = mem_req && !mem_ready;

  always_comb begin
    stall          = IDLE_STALL;
    pc_write       = IDLE_PC_WRITE;
    if_id_write    = IDLE_IF_ID_WRITE;
    if_id_flush    = IDLE_IF_ID_FLUSH;
    pipe_hold      = IDLE_PIPE_HOLD;
    state_nxt      = state;
    flush_pend_nxt = flush_pend;

    if (!rst) begin
      case (state)
        RUN: begin
          if (mem_wait) begin
            pipe_hold      = 1'b1;
            pc_write       = 1'b0;
            if_id_write    = 1'b0;
            state_nxt      = MEM_WAIT;
            // A branch resolving as the pipe freezes must still flush once memory returns
            flush_pend_nxt = ex_branch_taken;
          end else if (ex_branch_taken) begin
            stall       = 1'b1;
            if_id_flush = 1'b1;
          end else if (load_use) begin
            stall       = 1'b1;
            pc_write    = 1'b0;
            if_id_write = 1'b0;
          end
        end

        MEM_WAIT: begin
          if (mem_ready) begin
            state_nxt = flush_pend ? FLUSH_HOLD : RUN;
          end else begin
            pipe_hold   = 1'b1;
            pc_write    = 1'b0;
            if_id_write = 1'b0;
          end
        end

        FLUSH_HOLD: begin
          if (mem_wait) begin
            pipe_hold   = 1'b1;
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            state_nxt   = MEM_WAIT;
          end else begin
            stall          = 1'b1;
            if_id_flush    = 1'b1;
            state_nxt      = RUN;
            flush_pend_nxt = 1'b0;
          end
        end

        default: begin
          state_nxt      = RUN;
          flush_pend_nxt = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      flush_pend <= 1'b0;
    end else begin
      state      <= state_nxt;
      flush_pend <= flush_pend_nxt;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (if_id_flush),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed vectors with a scoreboard queue; control bits are {stall,pc_write,if_id_write,if_id_flush,pipe_hold}.
module tb_hazard_stall_unit;

  localparam int RW = 5;
  localparam int CW = 4;

  localparam logic [4:0] IDLE = 5'b01100;
  localparam logic [4:0] LU   = 5'b10000;
  localparam logic [4:0] FL   = 5'b11110;
  localparam logic [4:0] HOLD = 5'b00001;

  logic          clk = 1'b0;
  logic          rst;
  logic [RW-1:0] id_rs1, id_rs2, ex_rd;
  logic          id_uses_rs1, id_uses_rs2, ex_memread, ex_branch_taken, mem_req, mem_ready;
  logic          stall, pc_write, if_id_write, if_id_flush, pipe_hold;
  logic [CW-1:0] stall_cnt, flush_cnt;

  typedef struct packed {
    logic [4:0]    ctrl;
    logic [CW-1:0] sc;
    logic [CW-1:0] fc;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   n_vec = 0;
  int   n_err = 0;

  hazard_stall_unit #(.REG_ADDR_W(RW), .CNT_W(CW)) dut (
    .clk             (clk),
    .rst             (rst),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_uses_rs1     (id_uses_rs1),
    .id_uses_rs2     (id_uses_rs2),
    .ex_memread      (ex_memread),
    .ex_rd           (ex_rd),
    .ex_branch_taken (ex_branch_taken),
    .mem_req         (mem_req),
    .mem_ready       (mem_ready),
    .stall           (stall),
    .pc_write        (pc_write),
    .if_id_write     (if_id_write),
    .if_id_flush     (if_id_flush),
    .pipe_hold       (pipe_hold),
    .stall_cnt       (stall_cnt),
    .flush_cnt       (flush_cnt)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs and queue the outputs expected during that cycle
  task automatic vec(input logic r, input logic mr, input logic [RW-1:0] rd,
                     input logic [RW-1:0] rs1, input logic [RW-1:0] rs2,
                     input logic u1, input logic u2, input logic bt,
                     input logic mq, input logic my,
                     input logic [4:0] ex, input logic [CW-1:0] esc,
                     input logic [CW-1:0] efc);
    exp_t t;
    rst = r; ex_memread = mr; ex_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
    id_uses_rs1 = u1; id_uses_rs2 = u2; ex_branch_taken = bt;
    mem_req = mq; mem_ready = my;
    t.ctrl = ex; t.sc = esc; t.fc = efc;
    q.push_back(t);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic [CW-1:0] esc, input logic [CW-1:0] efc);
    vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, IDLE, esc, efc);
  endtask

  initial begin : monitor
    logic [4:0] act;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        n_vec++;
        act = {stall, pc_write, if_id_write, if_id_flush, pipe_hold};
        if (act !== e.ctrl) begin
          n_err++;
          $display("FAIL ctrl vec %0d: got %b want %b", n_vec, act, e.ctrl);
        end
        if (stall_cnt !== e.sc) begin
          n_err++;
          $display("FAIL stall_cnt vec %0d: got %0d want %0d", n_vec, stall_cnt, e.sc);
        end
        if (flush_cnt !== e.fc) begin
          n_err++;
          $display("FAIL flush_cnt vec %0d: got %0d want %0d", n_vec, flush_cnt, e.fc);
        end
        if (!pc_write && if_id_flush) begin
          n_err++;
          $display("FAIL pcw_flush vec %0d: got pc_write=0 if_id_flush=1 want not both", n_vec);
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout want $finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    rst = 1'b1; ex_memread = 0; ex_rd = 0; id_rs1 = 0; id_rs2 = 0;
    id_uses_rs1 = 0; id_uses_rs2 = 0; ex_branch_taken = 0; mem_req = 0; mem_ready = 0;
    repeat (2) @(posedge clk);
    #1;

    // reset forces idle even with a hazard present
    vec(1, 1, 5, 5, 0, 1, 0, 0, 0, 0, IDLE, 0, 0);
    // load-use on rs1, then clears
    vec(0, 1, 5, 5, 0, 1, 0, 0, 0, 0, LU,   0, 0);
    idle(1, 0);
    // ex_rd = 0 never stalls
    vec(0, 1, 0, 0, 0, 1, 0, 0, 0, 0, IDLE, 1, 0);
    vec(0, 1, 0, 0, 0, 0, 1, 0, 0, 0, IDLE, 1, 0);
    // load-use on rs2; matching rs1 without use does not stall
    vec(0, 1, 7, 3, 7, 1, 1, 0, 0, 0, LU,   1, 0);
    vec(0, 1, 7, 7, 0, 0, 0, 0, 0, 0, IDLE, 2, 0);
    // branch beats load-use
    vec(0, 1, 5, 5, 0, 1, 0, 1, 0, 0, FL,   2, 0);
    idle(3, 1);
    // three-cycle memory wait, release on the fourth
    vec(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, HOLD, 3, 1);
    vec(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, HOLD, 3, 1);
    vec(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, HOLD, 3, 1);
    vec(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, IDLE, 3, 1);
    vec(0, 1, 5, 5, 0, 1, 0, 0, 0, 0, LU,   3, 1);
    idle(4, 1);
    // memory wait entered with a taken branch; load-use while held is ignored
    vec(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, HOLD, 4, 1);
    vec(0, 1, 5, 5, 0, 1, 0, 0, 1, 0, HOLD, 4, 1);
    vec(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, IDLE, 4, 1);
    vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, FL,   4, 1);
    idle(5, 2);
    // flush hold pre-empted by a new memory wait keeps the pending flush
    vec(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, HOLD, 5, 2);
    vec(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, IDLE, 5, 2);
    vec(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, HOLD, 5, 2);
    vec(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, IDLE, 5, 2);
    vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, FL,   5, 2);
    idle(6, 3);
    // stall counter saturates at 15
    for (int i = 0; i < 20; i++) begin
      vec(0, 1, 9, 9, 0, 1, 0, 0, 0, 0, LU, (6 + i > 15) ? 4'd15 : 4'(6 + i), 3);
    end
    idle(15, 3);
    // reset while in memory wait
    vec(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, HOLD, 15, 3);
    vec(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, IDLE, 15, 3);
    idle(0, 0);
    vec(0, 1, 5, 5, 0, 1, 0, 0, 0, 0, LU,   0, 0);
    idle(1, 0);
    // reset drops a pending flush
    vec(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, HOLD, 1, 0);
    vec(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, IDLE, 1, 0);
    idle(0, 0);
    idle(0, 0);

    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
